// File: rtl/mc6809_pkg.sv
// Shared definitions for the 6809 DMA bus arbiter.
//   - arbState_t : arbiter FSM states
//   - GNT_ID_W   : width of the granted-channel index output
//   - BURST_W    : width of the remaining-burst counter output
//   - nextPtr()  : round-robin pointer advance, modulo channel count
package mc6809_pkg;

    localparam int GNT_ID_W = 3;
    localparam int BURST_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arbState_t;

    // Channel after idx, wrapping at nch. With nch == 1 this is always 0.
    function automatic logic [GNT_ID_W-1:0] nextPtr(input logic [GNT_ID_W-1:0] idx,
                                                    input int nch);
        int n;
        n = (int'(idx) + 1) % nch;
        return GNT_ID_W'(n);
    endfunction

endpackage

// File: rtl/mc6809_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req       in  NCH  request vector
//   ptr       in  3    channel with highest priority this round
//   winOneHot out NCH  one-hot winner (0 when no request)
//   winIdx    out 3    winner index (0 when no request)
//   anyValid  out 1    at least one request is pending
module mc6809_rr_pick
    import mc6809_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]      req,
    input  logic [GNT_ID_W-1:0] ptr,
    output logic [NCH-1:0]      winOneHot,
    output logic [GNT_ID_W-1:0] winIdx,
    output logic                anyValid
);

    // Scan channels starting at ptr and wrapping; the first set bit wins.
    always_comb begin
        int idx;
        idx       = 0;
        winOneHot = '0;
        winIdx    = '0;
        anyValid  = 1'b0;
        for (int off = 0; off < NCH; off++) begin
            idx = (int'(ptr) + off) % NCH;
            if (!anyValid && req[idx]) begin
                anyValid       = 1'b1;
                winIdx         = GNT_ID_W'(idx);
                winOneHot[idx] = 1'b1;
            end else begin
                anyValid = anyValid;
            end
        end
    end

endmodule

// File: rtl/mc6809_dma_arbiter.sv
// N-channel DMA bus arbiter for the 6809 core's nDMABREQ input.
// Collects channel requests, asks the core for the bus, waits for the
// bus-grant state (BA=1, BS=1) and hands the bus to one channel at a time
// in round-robin order, with each grant capped at MAX_BURST bus cycles.
// Ports:
//   CLK        in   1    system clock
//   RESET      in   1    synchronous active-high reset
//   CE         in   1    one-cycle strobe per 6809 bus cycle
//   REQ        in   NCH  per-channel level bus request
//   BA, BS     in   1    core bus-available / bus-status
//   nDMABREQ   out  1    active-low DMA request to the core
//   GNT        out  NCH  one-hot channel grant
//   GNT_ID     out  3    index of granted channel, 0 when none
//   BUSOWN     out  1    a channel currently owns the bus
//   BURST_LEFT out  8    remaining cycles in the current grant
module mc6809_dma_arbiter
    import mc6809_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int MAX_BURST = 14,
    parameter int HOLDOFF   = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CE,
    input  logic [NCH-1:0]      REQ,
    input  logic                BA,
    input  logic                BS,
    output logic                nDMABREQ,
    output logic [NCH-1:0]      GNT,
    output logic [GNT_ID_W-1:0] GNT_ID,
    output logic                BUSOWN,
    output logic [BURST_W-1:0]  BURST_LEFT
);

    arbState_t           state_r;
    logic [GNT_ID_W-1:0] ptr_r;
    logic [3:0]          holdoff_r;
    logic                nDmaBreq_r;
    logic [NCH-1:0]      gnt_r;
    logic [GNT_ID_W-1:0] gntId_r;
    logic                busOwn_r;
    logic [BURST_W-1:0]  burstLeft_r;

    logic [NCH-1:0]      pickOneHot_s;
    logic [GNT_ID_W-1:0] pickIdx_s;
    logic                pickValid_s;
    logic                ownerReq_s;
    logic                releaseNow_s;

    mc6809_rr_pick #(.NCH(NCH)) uPick (
        .req       (REQ),
        .ptr       (ptr_r),
        .winOneHot (pickOneHot_s),
        .winIdx    (pickIdx_s),
        .anyValid  (pickValid_s)
    );

    // Owner's request is read through the one-hot grant so no index range issue arises.
    always_comb begin
        ownerReq_s   = |(REQ & gnt_r);
        releaseNow_s = !ownerReq_s || (burstLeft_r == BURST_W'(1)) || !BA;
    end

    // Arbiter FSM; reset wins over CE, otherwise everything advances only on CE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            holdoff_r   <= 4'd0;
            nDmaBreq_r  <= 1'b1;
            gnt_r       <= '0;
            gntId_r     <= '0;
            busOwn_r    <= 1'b0;
            burstLeft_r <= '0;
        end else if (CE) begin
            case (state_r)
                ST_IDLE: begin
                    if (holdoff_r != 4'd0) begin
                        holdoff_r <= holdoff_r - 4'd1;
                    end else if (|REQ) begin
                        nDmaBreq_r <= 1'b0;
                        state_r    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!pickValid_s) begin
                        // All requesters gave up before the core handed over the bus.
                        nDmaBreq_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else if (BA && BS) begin
                        gnt_r       <= pickOneHot_s;
                        gntId_r     <= pickIdx_s;
                        busOwn_r    <= 1'b1;
                        burstLeft_r <= BURST_W'(MAX_BURST);
                        state_r     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (releaseNow_s) begin
                        gnt_r       <= '0;
                        gntId_r     <= '0;
                        busOwn_r    <= 1'b0;
                        burstLeft_r <= '0;
                        nDmaBreq_r  <= 1'b1;
                        ptr_r       <= nextPtr(gntId_r, NCH);
                        holdoff_r   <= 4'(HOLDOFF);
                        state_r     <= ST_RELEASE;
                    end else begin
                        burstLeft_r <= burstLeft_r - BURST_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Holdoff runs while the core is still dropping BA.
                    if (holdoff_r != 4'd0) begin
                        holdoff_r <= holdoff_r - 4'd1;
                    end
                    if (!BA && (holdoff_r == 4'd0)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    nDmaBreq_r  <= 1'b1;
                    gnt_r       <= '0;
                    gntId_r     <= '0;
                    busOwn_r    <= 1'b0;
                    burstLeft_r <= '0;
                end
            endcase
        end
    end

    assign nDMABREQ   = nDmaBreq_r;
    assign GNT        = gnt_r;
    assign GNT_ID     = gntId_r;
    assign BUSOWN     = busOwn_r;
    assign BURST_LEFT = burstLeft_r;

endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
module tb_mc6809_dma_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b0;
    logic [3:0] REQ = 4'b0000;
    logic       BA = 1'b0;
    logic       BS = 1'b0;
    logic       nDMABREQ;
    logic [3:0] GNT;
    logic [2:0] GNT_ID;
    logic       BUSOWN;
    logic [7:0] BURST_LEFT;

    int nVec = 0;
    int nMis = 0;
    int expQ[$];

    // {nDMABREQ, GNT, GNT_ID, BUSOWN, BURST_LEFT}
    logic [16:0] obs;
    assign obs = {nDMABREQ, GNT, GNT_ID, BUSOWN, BURST_LEFT};

    localparam logic [16:0] IDLE_OUT = {1'b1, 4'b0000, 3'd0, 1'b0, 8'd0};
    localparam logic [16:0] ARM_OUT  = {1'b0, 4'b0000, 3'd0, 1'b0, 8'd0};

    mc6809_dma_arbiter #(.NCH(4), .MAX_BURST(14), .HOLDOFF(1)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .REQ(REQ), .BA(BA), .BS(BS),
        .nDMABREQ(nDMABREQ), .GNT(GNT), .GNT_ID(GNT_ID), .BUSOWN(BUSOWN),
        .BURST_LEFT(BURST_LEFT)
    );

    always #5 CLK = ~CLK;

    // One CE edge followed by one non-CE edge; returns on a negedge.
    task automatic ce();
        CE = 1'b1;
        @(negedge CLK);
        CE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic doReset();
        RESET = 1'b1;
        CE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        REQ = 4'b0000; BA = 1'b0; BS = 1'b0;
        doReset();
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL reset_values got=%h want=%h", obs, IDLE_OUT);
        end
        for (int i = 0; i < 20; i++) begin
            ce();
            nVec++;
            if (obs !== IDLE_OUT) begin
                nMis++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, IDLE_OUT);
            end
        end
    endtask

    task automatic test_single_grant();
        int e;
        logic [16:0] want;
        REQ = 4'b0001;
        expQ.push_back(0);
        ce();
        nVec++;
        if (obs !== ARM_OUT) begin
            nMis++; $display("FAIL single_arm got=%h want=%h", obs, ARM_OUT);
        end
        ce(); ce();
        nVec++;
        if (obs !== ARM_OUT) begin
            nMis++; $display("FAIL single_wait_ba got=%h want=%h", obs, ARM_OUT);
        end
        BA = 1'b1; BS = 1'b1;
        ce();
        nVec++;
        if (expQ.size() == 0) begin
            nMis++; $display("FAIL single_queue got=empty want=entry");
        end else begin
            e = expQ.pop_front();
            want = {1'b0, 4'(1 << e), 3'(e), 1'b1, 8'd14};
            if (obs !== want) begin
                nMis++; $display("FAIL single_grant got=%h want=%h", obs, want);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            ce();
            want = {1'b0, 4'b0001, 3'd0, 1'b1, 8'(14 - k)};
            nVec++;
            if (obs !== want) begin
                nMis++; $display("FAIL single_count k=%0d got=%h want=%h", k, obs, want);
            end
        end
        REQ = 4'b0000;
        ce();
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL single_release got=%h want=%h", obs, IDLE_OUT);
        end
        BA = 1'b0; BS = 1'b0;
        ce(); ce(); ce();
    endtask

    task automatic test_burst_cap();
        int cnt;
        REQ = 4'b0001;
        ce();
        BA = 1'b1; BS = 1'b1;
        ce();
        nVec++;
        if (GNT !== 4'b0001) begin
            nMis++; $display("FAIL cap_first_grant got=%b want=0001", GNT);
        end
        cnt = 0;
        for (int i = 0; i < 40 && GNT != 4'b0000; i++) begin
            cnt++;
            ce();
        end
        nVec++;
        if (cnt !== 14) begin
            nMis++; $display("FAIL cap_length got=%0d want=14", cnt);
        end
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL cap_release got=%h want=%h", obs, IDLE_OUT);
        end
        // Core drops BA right away: one holdoff cycle, one IDLE cycle, then re-arm.
        BA = 1'b0; BS = 1'b0;
        ce();
        nVec++;
        if (nDMABREQ !== 1'b1) begin
            nMis++; $display("FAIL cap_holdoff1 got=%b want=1", nDMABREQ);
        end
        ce();
        nVec++;
        if (nDMABREQ !== 1'b1) begin
            nMis++; $display("FAIL cap_holdoff2 got=%b want=1", nDMABREQ);
        end
        ce();
        nVec++;
        if (nDMABREQ !== 1'b0) begin
            nMis++; $display("FAIL cap_rearm got=%b want=0", nDMABREQ);
        end
        BA = 1'b1; BS = 1'b1;
        ce();
        nVec++;
        if (obs !== {1'b0, 4'b0001, 3'd0, 1'b1, 8'd14}) begin
            nMis++; $display("FAIL cap_regrant got=%h want=%h", obs, {1'b0, 4'b0001, 3'd0, 1'b1, 8'd14});
        end
        REQ = 4'b0000;
        ce();
        BA = 1'b0; BS = 1'b0;
        ce(); ce(); ce();
    endtask

    task automatic test_round_robin();
        logic [3:0] prevGnt;
        int lastId;
        int e;
        doReset();
        REQ = 4'b1011;
        expQ.delete();
        expQ.push_back(0); expQ.push_back(1); expQ.push_back(3);
        expQ.push_back(0); expQ.push_back(1); expQ.push_back(3);
        prevGnt = 4'b0000;
        lastId = -1;
        for (int i = 0; i < 400 && expQ.size() != 0; i++) begin
            BA = ~nDMABREQ; BS = ~nDMABREQ;
            ce();
            if (GNT != 4'b0000 && prevGnt == 4'b0000) begin
                e = expQ.pop_front();
                nVec++;
                if (GNT_ID !== 3'(e) || GNT !== 4'(1 << e)) begin
                    nMis++; $display("FAIL rr_order got=%0d/%b want=%0d", GNT_ID, GNT, e);
                end
                nVec++;
                if (int'(GNT_ID) == lastId) begin
                    nMis++; $display("FAIL rr_repeat got=%0d want=not %0d", GNT_ID, lastId);
                end
                lastId = int'(GNT_ID);
            end
            prevGnt = GNT;
        end
        nVec++;
        if (expQ.size() != 0) begin
            nMis++; $display("FAIL rr_timeout got=%0d pending want=0", expQ.size());
        end
        REQ = 4'b0000; BA = 1'b0; BS = 1'b0;
    endtask

    task automatic test_reclaim_abort();
        doReset();
        REQ = 4'b0100;
        ce();
        BA = 1'b1; BS = 1'b1;
        ce();
        nVec++;
        if (obs !== {1'b0, 4'b0100, 3'd2, 1'b1, 8'd14}) begin
            nMis++; $display("FAIL reclaim_grant got=%h want=%h", obs, {1'b0, 4'b0100, 3'd2, 1'b1, 8'd14});
        end
        REQ = 4'b0101;   // higher-priority request must not steal the grant
        ce();
        nVec++;
        if (obs !== {1'b0, 4'b0100, 3'd2, 1'b1, 8'd13}) begin
            nMis++; $display("FAIL reclaim_nosteal got=%h want=%h", obs, {1'b0, 4'b0100, 3'd2, 1'b1, 8'd13});
        end
        BA = 1'b0;
        ce();
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL reclaim_release got=%h want=%h", obs, IDLE_OUT);
        end
        REQ = 4'b0000; BS = 1'b0;
        ce(); ce(); ce();
        REQ = 4'b0010;
        ce();
        nVec++;
        if (obs !== ARM_OUT) begin
            nMis++; $display("FAIL abort_arm got=%h want=%h", obs, ARM_OUT);
        end
        REQ = 4'b0000;
        ce();
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL abort_drop got=%h want=%h", obs, IDLE_OUT);
        end
        BA = 1'b1; BS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ce();
            nVec++;
            if (obs !== IDLE_OUT) begin
                nMis++; $display("FAIL abort_nogrant cyc=%0d got=%h want=%h", i, obs, IDLE_OUT);
            end
        end
        BA = 1'b0; BS = 1'b0;
    endtask

    task automatic test_reset_ce();
        doReset();
        REQ = 4'b0001;
        ce();
        BA = 1'b1; BS = 1'b1;
        ce(); ce(); ce();
        nVec++;
        if (obs !== {1'b0, 4'b0001, 3'd0, 1'b1, 8'd12}) begin
            nMis++; $display("FAIL gate_setup got=%h want=%h", obs, {1'b0, 4'b0001, 3'd0, 1'b1, 8'd12});
        end
        REQ = 4'b0000;   // would release, but CE is low
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            nVec++;
            if (obs !== {1'b0, 4'b0001, 3'd0, 1'b1, 8'd12}) begin
                nMis++; $display("FAIL gate_hold cyc=%0d got=%h want=%h", i, obs, {1'b0, 4'b0001, 3'd0, 1'b1, 8'd12});
            end
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        nVec++;
        if (obs !== IDLE_OUT) begin
            nMis++; $display("FAIL reset_mid_grant got=%h want=%h", obs, IDLE_OUT);
        end
        BA = 1'b0; BS = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_grant();
        test_burst_cap();
        test_round_robin();
        test_reclaim_abort();
        test_reset_ce();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mc6809_dma_arbiter.md
Name: mc6809_dma_arbiter

Overview:
Parametrised N-channel DMA bus arbiter that drives the 6809 core's nDMABREQ input, which the E-variant wrapper ties inactive. It collects per-channel bus requests, asserts nDMABREQ and waits for the core's bus-grant state (BA=1, BS=1). It then hands the bus to one channel at a time in round-robin order. Per-grant burst length is bounded so the core is never starved of its own bus cycles.

Parameters:
NCH, 4, number of requesting DMA channels (1..8)
MAX_BURST, 14, maximum bus cycles one grant may hold before forced release (1..255)
HOLDOFF, 1, CE cycles nDMABREQ stays high after a release before it may be reasserted (0..15)

Ports:
CLK  in  1  system clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
CE  in  1  one-cycle strobe per 6809 bus cycle (E-cycle enable); FSM and counters advance only when CE=1
REQ  in  NCH  per-channel bus request, level, held until the channel is done
BA  in  1  core bus-available output
BS  in  1  core bus-status output
nDMABREQ  out  1  to core; low requests DMA/bus
GNT  out  NCH  one-hot grant; at most one bit set
GNT_ID  out  3  index of the granted channel; 0 when none granted
BUSOWN  out  1  high while a channel owns the bus (address/data/RnW mux select)
BURST_LEFT  out  8  remaining cycles in the current grant

Behaviour:
- Reset values: nDMABREQ=1, GNT=0, GNT_ID=0, BUSOWN=0, BURST_LEFT=0, round-robin pointer=0, state=IDLE, holdoff counter=0.
- CE=0: all registers hold.
- FSM states are IDLE, ARM, GRANT, RELEASE.
- IDLE: if any REQ bit is set and the holdoff counter is 0, drive nDMABREQ=0 and go to ARM.
- ARM: keep nDMABREQ=0 and wait for BA=1 and BS=1 on a CE cycle.
  - On that cycle, select the winner: first set REQ bit at or after the pointer, wrapping modulo NCH.
  - Set GNT/GNT_ID to the winner, set BUSOWN=1, load BURST_LEFT=MAX_BURST, go to GRANT.
  - If all REQ bits drop before the grant, set nDMABREQ=1 and return to IDLE with no holdoff.
- GRANT: decrement BURST_LEFT each CE cycle.
  - Release when the granted channel's REQ falls, when BURST_LEFT reaches 1 (the last cycle), or when BA falls (core reclaim).
  - On release, on the same CE edge: clear GNT and BUSOWN, set BURST_LEFT=0, set nDMABREQ=1, move the pointer to winner+1 modulo NCH, load holdoff=HOLDOFF, go to RELEASE.
- RELEASE: wait for BA=0, and count holdoff down to 0 meanwhile; then go to IDLE.
  - The pointer update guarantees another pending channel wins the next round.
- Grant latency: GNT is set on the first CE edge where BA and BS are both 1. Grants never change mid-burst, even if a higher-priority REQ rises.
- Forced release at MAX_BURST means a channel that keeps REQ high re-arbitrates after holdoff, behind any other pending channels.
- REQ of non-granted channels changing during GRANT has no effect until the next arbitration.
- RESET mid-GRANT: GNT, BUSOWN and nDMABREQ return to their reset values on the next CLK edge, regardless of CE.
- NCH=1: round-robin degenerates; the pointer stays 0.
- GNT_ID is zero-extended; bits above clog2(NCH) are always 0.

Decomposition:
- Shared package mc6809_pkg holds:
  - the FSM state enum (IDLE/ARM/GRANT/RELEASE)
  - the GNT_ID width constant (3)
  - the BURST_LEFT width constant (8)
- One sub-module, mc6809_rr_pick: combinational round-robin picker.
  - Inputs: REQ vector, pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Parametrised by NCH.

Test Plan:
1. Reset then idle: RESET=1 for 2 CLK, REQ=0 -> nDMABREQ=1, GNT=0, BUSOWN=0, BURST_LEFT=0 for 20 CE cycles.
2. Single grant: REQ=0001, BA/BS raised 3 CE later -> nDMABREQ=0 on the first CE after REQ; GNT=0001 and BURST_LEFT=14 on the first CE with BA=BS=1; REQ drops after 5 cycles -> GNT=0 and nDMABREQ=1 on that CE.
3. Burst cap: REQ=0001 held with MAX_BURST=14 -> GNT high for exactly 14 CE cycles, then released; re-granted after BA falls and 1 holdoff cycle.
4. Round-robin fairness: REQ=1011 held, bus granted each round -> grant order 0,1,3,0,1,3, with no channel granted twice in a row while others pend.
5. Core reclaim and abort: BA falls mid-GRANT -> GNT=0 and BUSOWN=0 on that CE. Separately, REQ drops while in ARM -> nDMABREQ=1, IDLE, and no grant issued.
6. Reset mid-burst plus CE gating: RESET during GRANT with CE=0 -> all outputs reach reset values on the next CLK. With CE=0 otherwise, BURST_LEFT holds its value.
